cic_decim_mc: RTL and testbench

- Parametrised multi-channel CIC decimator; next generation of the team's single-channel cic_filter.
- Runs on one clock with a valid strobe instead of a divided clock.
- Takes a time-multiplexed stream of CH channels, each tagged with a channel index.
- Supports N stages, a runtime decimation ratio R = 2^os_sel (os_sel=0 is a bypass mode), exact gain normalisation, and a clean flush on ratio change.

---
 rtl/cic_pkg.sv | 17 +
 rtl/cic_comb_chain.sv | 19 +
 rtl/cic_decim_mc.sv | 161 ++++++++++++++++
 tb/tb_cic_decim_mc.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants, types and the ratio clamp for the multi-channel CIC decimator.
package cic_pkg;
  localparam int CIC_DW        = 16;
  localparam int CIC_N         = 3;
  localparam int CIC_MAX_LOG2R = 6;
  localparam int ACC_W         = CIC_DW + CIC_N * CIC_MAX_LOG2R;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef acc_t [CIC_N-1:0]        acc_arr_t;

  // Effective log2 of the decimation ratio; requests beyond the maximum saturate.
  function automatic logic [2:0] eff_log2r(input logic [2:0] os,
                                           input int max_l = CIC_MAX_LOG2R);
    if (int'(os) > max_l) return 3'(max_l);
    return os;
  endfunction
endpackage

// File: rtl/cic_comb_chain.sv
// Combinational N-stage comb (M=1): each stage subtracts its delay and hands its input on as the new delay.
module cic_comb_chain #(
  parameter int W = 34,
  parameter int N = 3
) (
  input  logic [W-1:0]        din,
  input  logic [N-1:0][W-1:0] dly,
  output logic [W-1:0]        dout,
  output logic [N-1:0][W-1:0] dly_nxt
);
  logic [N:0][W-1:0] stg;

  assign stg[0] = din;
  for (genvar k = 0; k < N; k++) begin : g_stage
    assign stg[k+1]   = stg[k] - dly[k];
    assign dly_nxt[k] = stg[k];
  end
  assign dout = stg[N];
endmodule

// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator: per-channel integrators/counters in stage 1, shared comb chain in stage 2.
module cic_decim_mc
  import cic_pkg::*;
#(
  parameter int DW        = CIC_DW,
  parameter int N         = CIC_N,
  parameter int MAX_LOG2R = CIC_MAX_LOG2R,
  parameter int CH        = 2,
  parameter int CHW       = $clog2(CH > 1 ? CH : 2)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [2:0]     os_sel,
  input  logic           in_valid,
  input  logic [CHW-1:0] in_ch,
  input  logic [DW-1:0]  data_in,
  output logic           out_valid,
  output logic [CHW-1:0] out_ch,
  output logic [DW-1:0]  data_out,
  output logic           cfg_err
);
  localparam int AW = DW + N * MAX_LOG2R;
  localparam int CW = MAX_LOG2R;

  logic [2:0]                   os_q, os_d, l_q, l_d, l_new;
  logic                         cfg_err_q, cfg_err_d;
  logic [CH-1:0][N-1:0][AW-1:0] integ_q, integ_d, dly_q, dly_d;
  logic [CH-1:0][CW-1:0]        dcnt_q, dcnt_d;
  logic                         s1_vld_q, s1_vld_d, s1_byp_q, s1_byp_d;
  logic [CHW-1:0]               s1_ch_q, s1_ch_d;
  logic [AW-1:0]                s1_acc_q, s1_acc_d;
  logic                         out_valid_q, out_valid_d;
  logic [CHW-1:0]               out_ch_q, out_ch_d;
  logic [DW-1:0]                data_out_q, data_out_d;

  logic                  clr, ch_ok, accept, dump;
  logic [CW-1:0]         mask;
  logic [AW-1:0]         x_ext, cc_out;
  logic [N-1:0][AW-1:0]  integ_new, cc_dly_nxt;
  logic signed [AW-1:0]  scaled;

  // A change of effective ratio wipes every channel before new-ratio data is accepted.
  assign l_new  = eff_log2r(os_q, MAX_LOG2R);
  assign clr    = (l_new != l_q);
  assign mask   = ~({CW{1'b1}} << l_q);
  assign x_ext  = {{(AW-DW){data_in[DW-1]}}, data_in};
  assign accept = in_valid & ch_ok & ~clr;
  assign dump   = (dcnt_q[in_ch] == mask);

  if (CH == (1 << CHW)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (int'(in_ch) < CH);
  end

  always_comb begin
    integ_new    = integ_q[in_ch];
    integ_new[0] = integ_q[in_ch][0] + x_ext;
    for (int k = 1; k < N; k++)
      integ_new[k] = integ_q[in_ch][k] + integ_new[k-1];
  end

  cic_comb_chain #(.W(AW), .N(N)) u_comb (
    .din     (s1_acc_q),
    .dly     (dly_q[s1_ch_q]),
    .dout    (cc_out),
    .dly_nxt (cc_dly_nxt)
  );

  // Gain is R^N = 2^(N*L), so normalisation is an exact arithmetic shift.
  assign scaled = $signed(cc_out) >>> (N * int'(l_q));

  always_comb begin
    os_d        = os_sel;
    l_d         = l_new;
    cfg_err_d   = (int'(os_sel) > MAX_LOG2R);
    integ_d     = integ_q;
    dly_d       = dly_q;
    dcnt_d      = dcnt_q;
    s1_vld_d    = 1'b0;
    s1_byp_d    = 1'b0;
    s1_ch_d     = s1_ch_q;
    s1_acc_d    = s1_acc_q;
    out_valid_d = s1_vld_q;
    out_ch_d    = out_ch_q;
    data_out_d  = data_out_q;

    if (accept) begin
      if (l_q == 3'd0) begin
        s1_vld_d = 1'b1;
        s1_byp_d = 1'b1;
        s1_ch_d  = in_ch;
        s1_acc_d = x_ext;
      end else begin
        integ_d[in_ch] = integ_new;
        dcnt_d[in_ch]  = (dcnt_q[in_ch] + 1'b1) & mask;
        if (dump) begin
          s1_vld_d = 1'b1;
          s1_ch_d  = in_ch;
          s1_acc_d = integ_new[N-1];
        end
      end
    end

    if (s1_vld_q) begin
      out_ch_d = s1_ch_q;
      if (s1_byp_q) begin
        data_out_d = s1_acc_q[DW-1:0];
      end else begin
        dly_d[s1_ch_q] = cc_dly_nxt;
        data_out_d     = scaled[DW-1:0];
      end
    end

    if (clr) begin
      integ_d     = '0;
      dly_d       = '0;
      dcnt_d      = '0;
      s1_vld_d    = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  // Reset loads the current ratio so release does not look like a ratio change.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      os_q        <= os_sel;
      l_q         <= eff_log2r(os_sel, MAX_LOG2R);
      cfg_err_q   <= 1'b0;
      integ_q     <= '0;
      dly_q       <= '0;
      dcnt_q      <= '0;
      s1_vld_q    <= 1'b0;
      s1_byp_q    <= 1'b0;
      s1_ch_q     <= '0;
      s1_acc_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      data_out_q  <= '0;
    end else begin
      os_q        <= os_d;
      l_q         <= l_d;
      cfg_err_q   <= cfg_err_d;
      integ_q     <= integ_d;
      dly_q       <= dly_d;
      dcnt_q      <= dcnt_d;
      s1_vld_q    <= s1_vld_d;
      s1_byp_q    <= s1_byp_d;
      s1_ch_q     <= s1_ch_d;
      s1_acc_q    <= s1_acc_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      data_out_q  <= data_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign data_out  = data_out_q;
  assign cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_cic_decim_mc.sv
// Bench for cic_decim_mc: convolution reference model (cascaded boxcar impulse response) plus bypass vector table.
module tb_cic_decim_mc;
  localparam int DW = 16, N = 3, MAXL = 6, CH = 2, CHW = 1, HMAX = 1024;

  logic           clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0;
  logic [2:0]     os_sel = 3'd2;
  logic [CHW-1:0] in_ch = '0;
  logic [DW-1:0]  data_in = '0;
  logic           out_valid, cfg_err;
  logic [CHW-1:0] out_ch;
  logic [DW-1:0]  data_out;

  int total = 0, bad = 0;

  typedef struct packed { logic v; logic [CHW-1:0] ch; logic [DW-1:0] d; } exp_t;
  typedef struct packed {
    logic v; logic [CHW-1:0] ch; logic [DW-1:0] d;
    logic ev; logic [CHW-1:0] ech; logic [DW-1:0] ed;
  } vec_t;

  exp_t        prev_e;
  logic [DW-1:0] last_d [CH];
  longint      hx [CH][HMAX];
  int          hn [CH];
  longint      h [256];
  int          hlen;
  int          m_l;

  always #5 clk = ~clk;

  cic_decim_mc #(.DW(DW), .N(N), .MAX_LOG2R(MAXL), .CH(CH)) dut (
    .clk(clk), .reset_n(reset_n), .os_sel(os_sel), .in_valid(in_valid),
    .in_ch(in_ch), .data_in(data_in), .out_valid(out_valid), .out_ch(out_ch),
    .data_out(data_out), .cfg_err(cfg_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int eff_l(input logic [2:0] os);
    return (int'(os) > MAXL) ? MAXL : int'(os);
  endfunction

  // Impulse response of N cascaded length-R boxcars (CIC with M=1).
  function automatic void build_h(input int l);
    longint t [256];
    int r = 1 << l;
    for (int i = 0; i < 256; i++) h[i] = 0;
    h[0] = 1;
    hlen = 1;
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < 256; i++) t[i] = 0;
      for (int i = 0; i < hlen; i++)
        for (int j = 0; j < r; j++) t[i+j] += h[i];
      hlen = hlen + r - 1;
      for (int i = 0; i < 256; i++) h[i] = t[i];
    end
  endfunction

  function automatic void m_clear();
    for (int c = 0; c < CH; c++) hn[c] = 0;
    build_h(m_l);
  endfunction

  function automatic exp_t model_beat(input logic v, input int ch, input int d);
    exp_t e;
    logic signed [DW-1:0] ds;
    longint y;
    int n, r;
    e.v = 1'b0; e.ch = ch[CHW-1:0]; e.d = d[DW-1:0];
    if (!v) return e;
    if (m_l == 0) begin e.v = 1'b1; return e; end
    ds = d[DW-1:0];
    n = hn[ch];
    if (n < HMAX) hx[ch][n] = longint'(ds);
    n++;
    hn[ch] = n;
    r = 1 << m_l;
    if (n % r == 0) begin
      y = 0;
      for (int j = 0; j < hlen && j < n && j < HMAX; j++) y += h[j] * hx[ch][n-1-j];
      y = y >>> (N * m_l);
      e.v = 1'b1;
      e.d = y[DW-1:0];
    end
    return e;
  endfunction

  task automatic check_out(input exp_t e);
    chk("out_valid", 32'(out_valid), 32'(e.v));
    if (e.v) begin
      chk("out_ch", 32'(out_ch), 32'(e.ch));
      chk("data_out", 32'(data_out), 32'(e.d));
    end
    if (out_valid === 1'b1) last_d[out_ch] = data_out;
  endtask

  task automatic cyc(input logic v, input int ch, input int d);
    exp_t e;
    int l;
    l = eff_l(os_sel);
    if (l != m_l) begin m_l = l; m_clear(); end
    e = model_beat(v, ch, d);
    in_valid = v; in_ch = ch[CHW-1:0]; data_in = d[DW-1:0];
    @(posedge clk); #1;
    check_out(prev_e);
    prev_e = e;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 0, 0);
  endtask

  task automatic rnd(input int nb, input int ch1_pct, input int gap_pct);
    for (int i = 0; i < nb; i++)
      cyc(($urandom_range(0, 99) >= gap_pct), ($urandom_range(0, 99) < ch1_pct) ? 1 : 0,
          int'($urandom_range(0, 65535)));
  endtask

  task automatic do_reset(input int ncyc);
    reset_n = 1'b0; in_valid = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    reset_n = 1'b1;
    m_l = eff_l(os_sel);
    m_clear();
    prev_e = '0;
  endtask

  initial begin
    vec_t tbl [10];
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[1] = '{1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b0, 16'h0000};
    tbl[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h7FFF};
    tbl[3] = '{1'b1, 1'b0, 16'h8000, 1'b0, 1'b0, 16'h0000};
    tbl[4] = '{1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 16'h8000};
    tbl[5] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234};
    tbl[6] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[7] = '{1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'h0000};
    tbl[8] = '{1'b1, 1'b1, 16'h0005, 1'b1, 1'b0, 16'hFFFF};
    tbl[9] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0005};
    last_d[0] = '0; last_d[1] = '0;
    prev_e = '0;

    os_sel = 3'd2;
    do_reset(2);

    // DC response, R=4: positive on ch0, full-scale negative on untouched ch1
    repeat (24) cyc(1'b1, 0, 1000);
    idle(3);
    chk("dc_pos_last", 32'(last_d[0]), 32'd1000);
    repeat (16) cyc(1'b1, 1, -32768);
    idle(3);
    chk("dc_neg_last", 32'(last_d[1]), 32'h8000);

    // Interleaved channels at R=2
    os_sel = 3'd1;
    idle(3);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 0, 500);
      cyc(1'b1, 1, -700);
    end
    idle(3);
    chk("il_ch0_last", 32'(last_d[0]), 32'h01F4);
    chk("il_ch1_last", 32'(last_d[1]), 32'hFD44);

    // Bypass: fixed vectors, then random with gaps
    os_sel = 3'd0;
    idle(3);
    for (int i = 0; i < 10; i++) begin
      in_valid = tbl[i].v; in_ch = tbl[i].ch; data_in = tbl[i].d;
      @(posedge clk); #1;
      chk("byp_valid", 32'(out_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk("byp_ch", 32'(out_ch), 32'(tbl[i].ech));
        chk("byp_data", 32'(data_out), 32'(tbl[i].ed));
      end
    end
    prev_e = '0;
    rnd(20, 50, 30);
    idle(3);

    // Ratio change mid-period: R=8 -> R=2
    os_sel = 3'd3;
    idle(3);
    rnd(30, 50, 0);
    idle(3);
    os_sel = 3'd1;
    idle(3);
    rnd(40, 50, 20);
    idle(3);

    // Out-of-range ratio clamps to MAX; 7->6 is not an effective change
    os_sel = 3'd7;
    idle(3);
    chk("cfg_err_hi", 32'(cfg_err), 32'd1);
    rnd(300, 25, 10);
    os_sel = 3'd6;
    cyc(1'b1, 0, int'($urandom_range(0, 65535)));
    chk("cfg_err_lo", 32'(cfg_err), 32'd0);
    rnd(60, 25, 10);
    os_sel = 3'd7;
    rnd(40, 25, 10);
    do_reset(1);
    rnd(200, 10, 0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
